// File: rtl/alu_pkg.sv
// Shared ALU control codes and arbiter state encoding for the shared-ALU sequencer.
package alu_pkg;

  localparam int unsigned ALU_CTLW = 3;

  localparam logic [ALU_CTLW-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTLW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTLW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTLW-1:0] ALU_NOP = 3'b011;
  localparam logic [ALU_CTLW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTLW-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arb_rr_grant2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side named by rr.
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one external combinational ALU between two requesters:
// accept one op, drive the ALU for one cycle, hold the captured result until consumed.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTLW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [CTLW-1:0]  req0_ctl,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [CTLW-1:0]  req1_ctl,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zf,

  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [CTLW-1:0]  alu_ctl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zf,

  output logic             busy
);

  localparam logic [CTLW-1:0] CTL_NOP = CTLW'(ALU_NOP);

  state_t           state;
  logic             rr;
  logic             owner;
  logic [WIDTH-1:0] lat_op1;
  logic [WIDTH-1:0] lat_op2;
  logic [CTLW-1:0]  lat_ctl;
  logic [1:0]       grant;
  logic             idle;
  logic             rsp_fire;

  rr_grant2 u_grant (
    .valid ({req1_valid, req0_valid}),
    .rr    (rr),
    .grant (grant)
  );

  // Ready is masked by reset so nothing looks accepted while rst_n is low.
  assign idle       = rst_n && (state == ST_IDLE);
  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];

  assign rsp0_valid = (state == ST_RESP) && !owner;
  assign rsp1_valid = (state == ST_RESP) &&  owner;
  assign rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy       = (state != ST_IDLE);

  // ALU inputs sit at NOP/zero outside EXEC to keep the datapath quiet.
  assign alu_op1 = (state == ST_EXEC) ? lat_op1 : '0;
  assign alu_op2 = (state == ST_EXEC) ? lat_op2 : '0;
  assign alu_ctl = (state == ST_EXEC) ? lat_ctl : CTL_NOP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr      <= 1'b0;
      owner   <= 1'b0;
      lat_op1 <= '0;
      lat_op2 <= '0;
      lat_ctl <= CTL_NOP;
      rsp_res <= '0;
      rsp_zf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant[1]) begin
            owner   <= 1'b1;
            lat_op1 <= req1_op1;
            lat_op2 <= req1_op2;
            lat_ctl <= req1_ctl;
            state   <= ST_EXEC;
          end else if (grant[0]) begin
            owner   <= 1'b0;
            lat_op1 <= req0_op1;
            lat_op2 <= req0_op2;
            lat_ctl <= req0_ctl;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_res <= alu_res;
          rsp_zf  <= alu_zf;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rr    <= ~owner;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port round-robin arbiter and sequencer that shares one 32-bit ALU between two requesters, such as the integer pipe and the address/branch unit. It accepts one operation at a time over a valid/ready request channel and drives the ALU's operand and control inputs from registered copies. It captures the ALU result and zero flag, then returns them on the winning requester's response channel. The ALU itself is instantiated beside this block in the parent; this block only sequences it.

## Interface
- WIDTH, 32, operand/result width
- CTLW, 3, ALU control code width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle (combinational)
- req0_op1, req0_op2 / req1_op1, req1_op2  in  WIDTH  operands
- req0_ctl / req1_ctl  in  CTLW  ALU control code (AND 000, OR 001, ADD 010, NOP 011, SUB 110, SLT 111)
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp_res  out  WIDTH  captured result, shared by both response channels
- rsp_zf  out  1  captured zero flag
- alu_op1, alu_op2  out  WIDTH  to ALU operand inputs
- alu_ctl  out  CTLW  to ALU control input
- alu_res  in  WIDTH  from ALU result
- alu_zf  in  1  from ALU zero flag
- busy  out  1  state is not IDLE

## Operation
- States:
  - IDLE: accepts one request.
  - EXEC: the ALU evaluates the latched operation.
  - RESP: holds the result until it is consumed.
- IDLE behaviour:
  - Grant rule:
    - Only one valid request: that requester is granted.
    - Both valid: the requester named by round-robin pointer `rr` is granted.
  - The granted reqN_ready is high only in IDLE. The other ready stays low.
  - Transfer happens on valid&&ready. Latch op1, op2, ctl and owner, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - Drive alu_op1/op2/ctl from the latched registers.
  - At the clock edge, capture alu_res into rsp_res and alu_zf into rsp_zf, then go to RESP.
- RESP:
  - rspN_valid is high for the owner only.
  - On rspN_valid&&rspN_ready: go to IDLE, and set rr to the other requester (rr = ~owner).
  - Otherwise hold. No new request is accepted while in RESP.
- ALU inputs outside EXEC: alu_ctl = NOP (011), alu_op1 = alu_op2 = 0. This prevents spurious switching.
- Control codes are passed through unchecked. Undefined codes (100, 101) yield whatever the ALU returns (0, zf = 1).
- SLT is the ALU's unsigned compare. This block does not reinterpret it.
- Requester rules:
  - The requester holds valid and payload stable until ready.
  - The arbiter samples the payload only in the accept cycle.
  - Dropping valid before ready is legal. The request is simply not served.
- rsp_res/rsp_zf hold their last value after consumption until the next EXEC capture.
- Reset values:
  - state = IDLE, rr = 0 (req0 favoured first), owner = 0.
  - Latched operands = 0, latched ctl = NOP, rsp_res = 0, rsp_zf = 0.
  - All ready/valid outputs = 0, busy = 0, alu_ctl = NOP.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and no response is issued. The requester must re-issue.

## Timing
- Accept at edge N (valid&&ready sampled) → EXEC during cycle N+1 → rspN_valid high in cycle N+2.
- Minimum occupancy is 3 cycles per operation (accept, exec, response consumed in its first cycle). Peak throughput is one op per 3 cycles.
- Next accept is possible in the cycle after response consumption.
- The ALU is combinational. The result is captured at the end of the single EXEC cycle. No multi-cycle ALU operations.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1…
  - Worst-case wait is one foreign transaction plus own.
- reqN_ready depends combinationally on reqN_valid, the other valid, rr and state. It has no dependence on rsp*_ready.

## Structure
- Shared package alu_pkg:
  - ALU control code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_NOP, ALU_SUB, ALU_SLT).
  - State encoding (ST_IDLE, ST_EXEC, ST_RESP).
- Sub-module rr_grant2: purely combinational 2-way round-robin pick.
  - Inputs: valid[1:0], rr.
  - Outputs: grant[1:0], one-hot or zero.
- FSM, latches and result capture live in alu_share_arb. The ALU is instantiated in the parent and wired to the alu_* ports.

## Test plan
- Reset: hold rst_n low 2 cycles with random inputs → all ready/valid low, busy = 0, alu_ctl = 011, rsp_res = 0.
- Single request: req0 ADD op1 = 5, op2 = 7, rsp0_ready = 1 → req0_ready at cycle 0, alu_ctl = 010 in cycle 1, rsp0_valid with rsp_res = 12 and rsp_zf = 0 in cycle 2, rsp1_valid never high.
- Contention: both valid after reset, req0 AND 0xF0F0/0x0FF0, req1 SUB 9−9 → req0 served first (rsp_res = 0x00F0), then req1 (rsp_res = 0, rsp_zf = 1). Continued contention alternates 0,1,0,1.
- Backpressure: req1 SLT 3<8 with rsp1_ready low 4 cycles while req0 valid → rsp1_valid and rsp_res = 1 held stable, req0_ready low throughout. req0 is accepted the cycle after rsp1_ready rises.
- Unsigned SLT: op1 = 0xFFFFFFFF, op2 = 1 → rsp_res = 0, rsp_zf = 1.
- Reset mid-EXEC: assert rst_n low during EXEC of req0 ADD → no rsp0_valid afterwards, state IDLE, rr = 0. A new req1 is then served normally.
